// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU opcodes, forward selects and the multiplier state encoding.
package pipeline_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Select 11 is unused by the hazard unit and falls back to the register file value.
  function automatic logic [31:0] select_operand(input logic [1:0]  sel,
                                                 input logic [31:0] reg_val,
                                                 input logic [31:0] wb_val,
                                                 input logic [31:0] mem_val);
    case (sel)
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

endpackage

// File: rtl/iter_multiplier.sv
// Shift-add multiplier, one partial product per cycle; keeps the low 32 bits of a*b.
module iter_multiplier
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam logic [4:0] LAST_ITER = 5'(MUL_CYCLES - 1);

  mul_state_t  state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] a_q, b_q, acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start && !abort) begin
        a_q     <= a;
        b_q     <= b;
        acc_q   <= '0;
        count_q <= '0;
      end else if (state_q == BUSY && !abort) begin
        if (b_q[0]) acc_q <= acc_q + a_q;
        a_q     <= a_q << 1;
        b_q     <= b_q >> 1;
        count_q <= count_q + 5'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (count_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM register.
// Define EXEC_MUL_EN to include the iterative multiplier; otherwise MUL decodes as an unknown op.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_E,
  input  logic        MemToReg_E,
  input  logic        MemRead_E,
  input  logic        MemWrite_E,
  input  logic        JumpAndLink_E,
  input  logic        AluSrc_E,
  input  logic [3:0]  AluCtrl_E,
  input  logic [31:0] ReadData1_E,
  input  logic [31:0] ReadData2_E,
  input  logic [31:0] Imm_E,
  input  logic [4:0]  RegisterD_E,
  input  logic [4:0]  Pc_E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] AluResult_Mfwd,
  input  logic [31:0] WriteBackData_W,
  input  logic        Flush_E,
  output logic        Stall_E,
  output logic        MemRead_M,
  output logic        MemToReg_M,
  output logic        MemWrite_M,
  output logic        RegWrite_M,
  output logic        JumpAndLink_M,
  output logic [31:0] AluResult_M,
  output logic [31:0] ReadData2_M,
  output logic [4:0]  RegisterD_M,
  output logic [4:0]  Pc_M
);

  logic [31:0] op_a, op_b_pre, op_b, alu_result;
  logic        bubble;

  assign op_a     = select_operand(ForwardA_E, ReadData1_E, WriteBackData_W, AluResult_Mfwd);
  assign op_b_pre = select_operand(ForwardB_E, ReadData2_E, WriteBackData_W, AluResult_Mfwd);
  assign op_b     = AluSrc_E ? Imm_E : op_b_pre;

`ifdef EXEC_MUL_EN
  logic        is_mul, mul_start, mul_busy, mul_done;
  logic [31:0] mul_product;

  assign is_mul    = (AluCtrl_E == ALU_MUL);
  assign mul_start = is_mul && !mul_busy && !mul_done && !Flush_E;
  // The DONE cycle is the one cycle a MUL in EX lets the pipeline advance.
  assign Stall_E   = is_mul && !mul_done && !Flush_E;

  iter_multiplier #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .abort  (Flush_E),
    .a      (op_a),
    .b      (op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );
`else
  assign Stall_E = 1'b0;
`endif

  always_comb begin
    alu_result = '0;
    case (AluCtrl_E)
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_SLT: alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
      ALU_NOR: alu_result = ~(op_a | op_b);
`ifdef EXEC_MUL_EN
      ALU_MUL: alu_result = mul_product;
`endif
      default: alu_result = '0;
    endcase
  end

  assign bubble = Flush_E || Stall_E;

  // A bubble clears data fields too, so stale operands never leak into MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MemRead_M     <= 1'b0;
      MemToReg_M    <= 1'b0;
      MemWrite_M    <= 1'b0;
      RegWrite_M    <= 1'b0;
      JumpAndLink_M <= 1'b0;
      AluResult_M   <= '0;
      ReadData2_M   <= '0;
      RegisterD_M   <= '0;
      Pc_M          <= '0;
    end else if (bubble) begin
      MemRead_M     <= 1'b0;
      MemToReg_M    <= 1'b0;
      MemWrite_M    <= 1'b0;
      RegWrite_M    <= 1'b0;
      JumpAndLink_M <= 1'b0;
      AluResult_M   <= '0;
      ReadData2_M   <= '0;
      RegisterD_M   <= '0;
      Pc_M          <= '0;
    end else begin
      MemRead_M     <= MemRead_E;
      MemToReg_M    <= MemToReg_E;
      MemWrite_M    <= MemWrite_E;
      RegWrite_M    <= RegWrite_E;
      JumpAndLink_M <= JumpAndLink_E;
      AluResult_M   <= alu_result;
      ReadData2_M   <= op_b_pre;
      RegisterD_M   <= RegisterD_E;
      Pc_M          <= Pc_E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a vector table for single-cycle ops plus multiply,
// flush and reset sequences (the multiply sequences need EXEC_MUL_EN).
module tb_execute_stage;
  import pipeline_pkg::*;

  logic        clk, reset;
  logic        RegWrite_E, MemToReg_E, MemRead_E, MemWrite_E, JumpAndLink_E, AluSrc_E;
  logic [3:0]  AluCtrl_E;
  logic [31:0] ReadData1_E, ReadData2_E, Imm_E;
  logic [4:0]  RegisterD_E, Pc_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] AluResult_Mfwd, WriteBackData_W;
  logic        Flush_E, Stall_E;
  logic        MemRead_M, MemToReg_M, MemWrite_M, RegWrite_M, JumpAndLink_M;
  logic [31:0] AluResult_M, ReadData2_M;
  logic [4:0]  RegisterD_M, Pc_M;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm;
    logic        aluSrc;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] mfwd, wb;
    logic        flush;
    logic [4:0]  ctrl;
    logic [4:0]  regD, pc;
    logic [31:0] expResult, expRd2;
  } vec_t;

  vec_t vecs[$];
  int   vectorCount = 0;
  int   missCount   = 0;

  execute_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_E(RegWrite_E), .MemToReg_E(MemToReg_E), .MemRead_E(MemRead_E),
    .MemWrite_E(MemWrite_E), .JumpAndLink_E(JumpAndLink_E), .AluSrc_E(AluSrc_E),
    .AluCtrl_E(AluCtrl_E), .ReadData1_E(ReadData1_E), .ReadData2_E(ReadData2_E),
    .Imm_E(Imm_E), .RegisterD_E(RegisterD_E), .Pc_E(Pc_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .AluResult_Mfwd(AluResult_Mfwd), .WriteBackData_W(WriteBackData_W),
    .Flush_E(Flush_E), .Stall_E(Stall_E),
    .MemRead_M(MemRead_M), .MemToReg_M(MemToReg_M), .MemWrite_M(MemWrite_M),
    .RegWrite_M(RegWrite_M), .JumpAndLink_M(JumpAndLink_M),
    .AluResult_M(AluResult_M), .ReadData2_M(ReadData2_M),
    .RegisterD_M(RegisterD_M), .Pc_M(Pc_M)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] allOutputs();
    return {17'd0, MemRead_M, MemToReg_M, MemWrite_M, RegWrite_M, JumpAndLink_M,
            AluResult_M, ReadData2_M, RegisterD_M, Pc_M};
  endfunction

  function automatic vec_t mkVec(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [31:0] imm, input logic aluSrc, input logic [1:0] fwdA,
                                 input logic [1:0] fwdB, input logic [31:0] mfwd, input logic [31:0] wb,
                                 input logic flush, input logic [4:0] ctrl, input logic [4:0] regD,
                                 input logic [4:0] pc, input logic [31:0] expResult,
                                 input logic [31:0] expRd2);
    vec_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.aluSrc = aluSrc;
    v.fwdA = fwdA; v.fwdB = fwdB; v.mfwd = mfwd; v.wb = wb; v.flush = flush;
    v.ctrl = ctrl; v.regD = regD; v.pc = pc; v.expResult = expResult; v.expRd2 = expRd2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    AluCtrl_E       = v.op;
    ReadData1_E     = v.rd1;
    ReadData2_E     = v.rd2;
    Imm_E           = v.imm;
    AluSrc_E        = v.aluSrc;
    ForwardA_E      = v.fwdA;
    ForwardB_E      = v.fwdB;
    AluResult_Mfwd  = v.mfwd;
    WriteBackData_W = v.wb;
    Flush_E         = v.flush;
    {MemRead_E, MemToReg_E, MemWrite_E, RegWrite_E, JumpAndLink_E} = v.ctrl;
    RegisterD_E     = v.regD;
    Pc_E            = v.pc;
  endtask

  task automatic runVector(input string name, input vec_t v);
    logic [4:0]  expCtrl;
    logic [9:0]  expRegPc;
    applyStimulus(v);
    #1;
    checkOutput({name, " stall"}, {31'd0, Stall_E}, 32'd0);
    tick();
    expCtrl  = v.flush ? 5'd0 : v.ctrl;
    expRegPc = v.flush ? 10'd0 : {v.regD, v.pc};
    checkOutput({name, " result"}, AluResult_M, v.flush ? 32'd0 : v.expResult);
    checkOutput({name, " store data"}, ReadData2_M, v.flush ? 32'd0 : v.expRd2);
    checkOutput({name, " control"},
                {27'd0, MemRead_M, MemToReg_M, MemWrite_M, RegWrite_M, JumpAndLink_M},
                {27'd0, expCtrl});
    checkOutput({name, " rd/pc"}, {22'd0, RegisterD_M, Pc_M}, {22'd0, expRegPc});
  endtask

  // Starts a MUL at the current time; when viaFwd is set, A comes from the MEM forward
  // path and that path is disturbed after the operands have been captured.
  task automatic runMul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expProd, input bit viaFwd);
    int stalls  = 0;
    int bubbles = 0;
    applyStimulus(mkVec(ALU_MUL, viaFwd ? 32'hDEAD0000 : a, b, 32'd0, 1'b0,
                        viaFwd ? FWD_MEM : FWD_REG, FWD_REG, a, 32'h0, 1'b0,
                        5'b00010, 5'd7, 5'd9, 32'd0, 32'd0));
    #1;
    while (Stall_E && stalls < 100) begin
      stalls++;
      if (viaFwd && stalls == 3) AluResult_Mfwd = 32'h0000_0099;
      tick();
      if (allOutputs() == 96'd0) bubbles++;
    end
    checkOutput({name, " stall cycles"}, stalls, 32'd33);
    checkOutput({name, " bubbles"}, bubbles, 32'd33);
    tick();
    checkOutput({name, " product"}, AluResult_M, expProd);
    checkOutput({name, " regwrite"}, {31'd0, RegWrite_M}, 32'd1);
    checkOutput({name, " store data"}, ReadData2_M, b);
    checkOutput({name, " rd"}, {27'd0, RegisterD_M}, 32'd7);
  endtask

  initial begin
    applyStimulus(mkVec(ALU_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0));
    reset = 1'b0;
    #3;
    checkOutput("reset outputs", {31'd0, |allOutputs()}, 32'd0);
    checkOutput("reset stall", {31'd0, Stall_E}, 32'd0);
    #10 reset = 1'b1;
    tick();

    vecs.push_back(mkVec(ALU_ADD, 32'h7FFFFFFF, 32'h1, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00010, 5'd3, 5'd4, 32'h80000000, 32'h1));
    vecs.push_back(mkVec(ALU_SLT, 32'hFFFFFFFF, 32'h1, 0, 0, FWD_MEM, FWD_REG, 32'd5, 0, 0, 5'b00010, 5'd5, 5'd6, 32'd0, 32'h1));
    vecs.push_back(mkVec(ALU_SLT, 32'hFFFFFFFF, 32'h1, 0, 0, FWD_REG, FWD_REG, 32'd5, 0, 0, 5'b00010, 5'd5, 5'd6, 32'd1, 32'h1));
    vecs.push_back(mkVec(ALU_SUB, 32'd5, 32'd7, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00011, 5'd31, 5'd31, 32'hFFFFFFFE, 32'd7));
    vecs.push_back(mkVec(ALU_AND, 32'hF0F01234, 32'h0000DEAD, 32'h0000FF0F, 1, FWD_REG, FWD_REG, 0, 0, 0, 5'b11010, 5'd8, 5'd1, 32'h00001204, 32'h0000DEAD));
    vecs.push_back(mkVec(ALU_OR, 32'h000000F0, 32'h12345678, 0, 0, FWD_REG, FWD_WB, 0, 32'h00000F00, 0, 5'b00010, 5'd2, 5'd2, 32'h00000FF0, 32'h00000F00));
    vecs.push_back(mkVec(ALU_NOR, 32'd0, 32'd0, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00010, 5'd9, 5'd10, 32'hFFFFFFFF, 32'd0));
    vecs.push_back(mkVec(ALU_ADD, 32'd10, 32'd1, 0, 0, 2'b11, 2'b11, 32'd100, 32'd1000, 0, 5'b00010, 5'd11, 5'd12, 32'd11, 32'd1));
    vecs.push_back(mkVec(ALU_SUB, 32'd0, 32'd9, 0, 0, FWD_REG, FWD_MEM, 32'd1, 0, 0, 5'b00100, 5'd13, 5'd14, 32'hFFFFFFFF, 32'd1));
    vecs.push_back(mkVec(ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00010, 5'd15, 5'd16, 32'd1, 32'h7FFFFFFF));
    vecs.push_back(mkVec(ALU_ADD, 32'd5, 32'h000000AA, 32'hFFFFFFFE, 1, FWD_REG, FWD_REG, 0, 0, 0, 5'b00100, 5'd17, 5'd18, 32'd3, 32'h000000AA));
    vecs.push_back(mkVec(4'b0011, 32'd1, 32'd2, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00010, 5'd19, 5'd20, 32'd0, 32'd2));
    vecs.push_back(mkVec(ALU_ADD, 32'd1, 32'd2, 0, 0, FWD_REG, FWD_REG, 0, 0, 1, 5'b11111, 5'd21, 5'd22, 32'd3, 32'd2));
    vecs.push_back(mkVec(ALU_ADD, 32'd100, 32'd0, 32'd4, 1, FWD_REG, FWD_WB, 0, 32'hCAFEBABE, 0, 5'b00100, 5'd23, 5'd24, 32'd104, 32'hCAFEBABE));
    vecs.push_back(mkVec(ALU_MUL, 32'd6, 32'd7, 0, 0, FWD_REG, FWD_REG, 0, 0, 1, 5'b00010, 5'd25, 5'd26, 32'd0, 32'd7));
`ifndef EXEC_MUL_EN
    vecs.push_back(mkVec(ALU_MUL, 32'd6, 32'd7, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00010, 5'd27, 5'd28, 32'd0, 32'd7));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset must clear a populated EX/MEM register without waiting for an edge.
    runVector("pre-reset add", mkVec(ALU_ADD, 32'd2, 32'd2, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b11111, 5'd1, 5'd2, 32'd4, 32'd2));
    #3 reset = 1'b0;
    #1 checkOutput("async reset clears", {31'd0, |allOutputs()}, 32'd0);
    #2 reset = 1'b1;
    tick();

`ifdef EXEC_MUL_EN
    runMul("mul 6x7", 32'd6, 32'd7, 32'd42, 1'b1);
    runMul("mul ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);

    applyStimulus(mkVec(ALU_MUL, 32'd5, 32'd9, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00010, 5'd7, 5'd9, 0, 0));
    tick();
    for (int i = 1; i < 10; i++) tick();
    checkOutput("busy stall", {31'd0, Stall_E}, 32'd1);
    Flush_E = 1'b1;
    #1 checkOutput("flush in busy stall", {31'd0, Stall_E}, 32'd0);
    tick();
    checkOutput("flush in busy bubble", {31'd0, |allOutputs()}, 32'd0);
    Flush_E = 1'b0;
    runMul("mul after flush", 32'd5, 32'd9, 32'd45, 1'b0);

    applyStimulus(mkVec(ALU_MUL, 32'd3, 32'd4, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00010, 5'd7, 5'd9, 0, 0));
    for (int i = 0; i < 6; i++) tick();
    #3 reset = 1'b0;
    #1 checkOutput("reset mid mul", {31'd0, |allOutputs()}, 32'd0);
    #2 reset = 1'b1;
    runVector("add after reset", mkVec(ALU_ADD, 32'd2, 32'd3, 0, 0, FWD_REG, FWD_REG, 0, 0, 0, 5'b00010, 5'd4, 5'd5, 32'd5, 32'd3));
    runMul("mul after reset", 32'd3, 32'd4, 32'd12, 1'b0);
    runMul("mul back-to-back", 32'd11, 32'd13, 32'd143, 1'b0);
    applyStimulus(mkVec(ALU_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0));
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
